// File: rtl/envelope_follower.sv
// rtl/envelope_follower.sv - audio envelope follower with attack/release smoothing and hysteretic note gate
// Three-stage pipeline: rectify/quantise, 8.8 one-pole envelope, then gate FSM on each new amplitude.
module envelope_follower #(
    parameter int SAMPLE_BITS = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sample_valid,
    input  logic [SAMPLE_BITS-1:0] din,
    input  logic [3:0]             a,
    input  logic [3:0]             r,
    input  logic [3:0]             threshold,
    input  logic [3:0]             hold,
    output logic [7:0]             amplitude,
    output logic                   amplitude_valid,
    output logic                   gate
);

    localparam int MAG_BITS = SAMPLE_BITS - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPEN = 2'd1,
        HOLD = 2'd2
    } gate_state_t;

    logic [MAG_BITS-1:0] mag;
    logic [7:0]          level_d, level_q;
    logic                s1_valid_d, s1_valid_q;
    logic [15:0]         env_d, env_q;
    logic [15:0]         target, diff, step;
    logic [7:0]          amplitude_d, amplitude_q;
    logic                amplitude_valid_d, amplitude_valid_q;
    logic [7:0]          on_level, off_level;
    logic                open_cond, close_cond;
    gate_state_t         state_q;
    logic [11:0]         hold_cnt_q;
    logic                gate_q;

    // Most negative input has no positive twin; clamp it to full scale.
    always_comb begin
        mag = din[MAG_BITS-1:0];
        if (din[SAMPLE_BITS-1]) begin
            if (din[MAG_BITS-1:0] == '0) begin
                mag = '1;
            end else begin
                mag = ~din[MAG_BITS-1:0] + MAG_BITS'(1);
            end
        end
        level_d    = sample_valid ? 8'(mag >> (MAG_BITS - 8)) : level_q;
        s1_valid_d = sample_valid;
    end

    always_comb begin
        target = {level_q, 8'h00};
        if (target > env_q) begin
            diff = target - env_q;
            step = diff >> a;
        end else begin
            diff = env_q - target;
            step = diff >> r;
        end
        // A tiny residual would otherwise stall the envelope short of its target.
        if (step == 16'd0 && diff != 16'd0) begin
            step = 16'd1;
        end
        env_d = env_q;
        if (s1_valid_q) begin
            if (target > env_q) begin
                env_d = env_q + step;
            end else begin
                env_d = env_q - step;
            end
        end
        amplitude_d       = s1_valid_q ? env_d[15:8] : amplitude_q;
        amplitude_valid_d = s1_valid_q;
    end

    always_comb begin
        on_level   = {threshold, 4'b0000};
        off_level  = (threshold == 4'd0) ? 8'd0 : on_level - 8'd16;
        open_cond  = amplitude_q > on_level;
        close_cond = amplitude_q <= off_level;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_q           <= 8'd0;
            s1_valid_q        <= 1'b0;
            env_q             <= 16'd0;
            amplitude_q       <= 8'd0;
            amplitude_valid_q <= 1'b0;
        end else begin
            level_q           <= level_d;
            s1_valid_q        <= s1_valid_d;
            env_q             <= env_d;
            amplitude_q       <= amplitude_d;
            amplitude_valid_q <= amplitude_valid_d;
        end
    end

    // Gate decisions happen only on the cycle a fresh amplitude is presented.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            hold_cnt_q <= 12'd0;
            gate_q     <= 1'b0;
        end else if (amplitude_valid_q) begin
            case (state_q)
                IDLE: begin
                    if (open_cond) begin
                        state_q <= OPEN;
                        gate_q  <= 1'b1;
                    end
                end
                OPEN: begin
                    if (close_cond) begin
                        if (hold != 4'd0) begin
                            state_q    <= HOLD;
                            hold_cnt_q <= {hold, 8'h00};
                        end else begin
                            state_q <= IDLE;
                            gate_q  <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (open_cond) begin
                        state_q    <= OPEN;
                        hold_cnt_q <= 12'd0;
                    end else if (hold_cnt_q <= 12'd1) begin
                        state_q    <= IDLE;
                        hold_cnt_q <= 12'd0;
                        gate_q     <= 1'b0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - 12'd1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    hold_cnt_q <= 12'd0;
                    gate_q     <= 1'b0;
                end
            endcase
        end
    end

    assign amplitude       = amplitude_q;
    assign amplitude_valid = amplitude_valid_q;
    assign gate            = gate_q;

endmodule

// File: tb/tb_envelope_follower.sv
// tb/tb_envelope_follower.sv - self-checking bench for envelope_follower against a behavioural model
module tb_envelope_follower;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sample_valid = 1'b0;
    logic [11:0] din = 12'd0;
    logic [3:0]  a = 4'd0;
    logic [3:0]  r = 4'd0;
    logic [3:0]  threshold = 4'd0;
    logic [3:0]  hold = 4'd0;
    logic [7:0]  amplitude;
    logic        amplitude_valid;
    logic        gate;

    int checks = 0;
    int errors = 0;

    int m_env, m_amp, m_av, m_lvl, m_s1v, m_state, m_cnt;
    int amp_log[$];
    int gate_dropped;

    envelope_follower #(.SAMPLE_BITS(12)) dut (
        .clk            (clk),
        .rst            (rst),
        .sample_valid   (sample_valid),
        .din            (din),
        .a              (a),
        .r              (r),
        .threshold      (threshold),
        .hold           (hold),
        .amplitude      (amplitude),
        .amplitude_valid(amplitude_valid),
        .gate           (gate)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int level_of(input int d);
        int m;
        m = (d < 0) ? -d : d;
        if (m > 2047) m = 2047;
        return m / 8;
    endfunction

    task automatic model_reset();
        m_env = 0; m_amp = 0; m_av = 0; m_lvl = 0; m_s1v = 0; m_state = 0; m_cnt = 0;
    endtask

    // One clock of the reference: gate reacts to last published amplitude,
    // envelope moves toward the last accepted level, new sample is quantised.
    task automatic model_step();
        int on_l, off_l, target, diff, stp, new_av;
        bit op, cl;
        if (m_av != 0) begin
            on_l  = threshold * 16;
            off_l = (on_l >= 16) ? on_l - 16 : 0;
            op = m_amp > on_l;
            cl = m_amp <= off_l;
            if (m_state == 0) begin
                if (op) m_state = 1;
            end else if (m_state == 1) begin
                if (cl) begin
                    if (hold != 0) begin m_state = 2; m_cnt = hold * 256; end
                    else m_state = 0;
                end
            end else begin
                if (op) begin m_state = 1; m_cnt = 0; end
                else begin
                    m_cnt = m_cnt - 1;
                    if (m_cnt == 0) m_state = 0;
                end
            end
        end
        new_av = m_s1v;
        if (m_s1v != 0) begin
            target = m_lvl * 256;
            diff = target - m_env;
            if (diff > 0) begin
                stp = diff / (1 << a);
                if (stp == 0) stp = 1;
                m_env = m_env + stp;
            end else if (diff < 0) begin
                stp = (-diff) / (1 << r);
                if (stp == 0) stp = 1;
                m_env = m_env - stp;
            end
            m_amp = m_env / 256;
        end
        m_s1v = sample_valid ? 1 : 0;
        if (sample_valid) m_lvl = level_of(int'($signed(din)));
        m_av = new_av;
    endtask

    task automatic cyc();
        @(posedge clk);
        if (!rst) model_reset();
        else model_step();
        #1;
        check("amp", 32'(amplitude), m_amp);
        check("av", 32'(amplitude_valid), m_av);
        check("gate", 32'(gate), (m_state != 0) ? 1 : 0);
        if (amplitude_valid) amp_log.push_back(int'(amplitude));
        if (!gate) gate_dropped = 1;
    endtask

    task automatic send(input int d);
        logic [31:0] v;
        v = d;
        sample_valid = 1'b1;
        din = v[11:0];
        cyc();
        sample_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        check("rst_amp", 32'(amplitude), 0);
        check("rst_av", 32'(amplitude_valid), 0);
        check("rst_gate", 32'(gate), 0);
        cyc();
        cyc();
        rst = 1'b1;
    endtask

    initial begin
        int exp_ramp[7] = '{64, 96, 112, 120, 124, 126, 127};
        int hi_cnt, mx;
        bit done;

        do_reset();

        a = 4'd0; r = 4'd0;
        send(-2048); cyc();
        check("direct_neg_full", 32'(amplitude), 255);
        check("direct_neg_av", 32'(amplitude_valid), 1);
        send(2047); cyc();
        check("direct_pos_full", 32'(amplitude), 255);
        send(0); cyc();
        check("direct_zero", 32'(amplitude), 0);
        cyc();
        check("direct_av_single", 32'(amplitude_valid), 0);

        do_reset();
        a = 4'd1;
        amp_log.delete();
        repeat (16) send(1024);
        cyc(); cyc(); cyc();
        check("ramp_count", amp_log.size(), 16);
        if (amp_log.size() == 16) begin
            for (int i = 0; i < 7; i++) check($sformatf("ramp_%0d", i), amp_log[i], exp_ramp[i]);
            check("ramp_final", amp_log[15], 128);
            mx = 0;
            foreach (amp_log[i]) if (amp_log[i] > mx) mx = amp_log[i];
            check("ramp_no_overshoot", mx, 128);
        end

        do_reset();
        a = 4'd0; r = 4'd0; threshold = 4'd4; hold = 4'd0;
        send(560); cyc(); cyc();
        check("hyst_open70", 32'(gate), 1);
        send(480); cyc(); cyc();
        check("hyst_keep60", 32'(gate), 1);
        send(392); cyc(); cyc();
        check("hyst_keep49", 32'(gate), 1);
        send(384); cyc(); cyc();
        check("hyst_close48", 32'(gate), 0);

        do_reset();
        threshold = 4'd4; hold = 4'd1;
        send(800); cyc(); cyc();
        check("hold_open", 32'(gate), 1);
        hi_cnt = 0; done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            send(0); cyc(); cyc();
            if (gate) hi_cnt++;
            else done = 1;
        end
        check("hold_length", hi_cnt, 256);
        check("hold_closed", 32'(gate), 0);

        send(800); cyc(); cyc();
        gate_dropped = 0;
        for (int i = 1; i <= 99; i++) begin
            send(0); cyc(); cyc();
        end
        send(640); cyc(); cyc();
        repeat (20) begin
            send(0); cyc(); cyc();
        end
        check("hold_reopen_no_drop", gate_dropped, 0);

        do_reset();
        a = 4'd0; threshold = 4'd4; hold = 4'd0;
        send(1600); cyc(); cyc();
        check("mid_amp200", 32'(amplitude), 200);
        check("mid_gate1", 32'(gate), 1);
        send(400);
        amp_log.delete();
        do_reset();
        repeat (4) cyc();
        check("mid_no_inflight_pulse", amp_log.size(), 0);

        do_reset();
        amp_log.delete();
        for (int i = 0; i < 1000; i++) begin
            if (i % 100 == 0) begin
                a = 4'($urandom_range(0, 15));
                r = 4'($urandom_range(0, 15));
                threshold = 4'($urandom_range(0, 15));
                hold = 4'($urandom_range(0, 1));
            end
            sample_valid = 1'b1;
            din = 12'($urandom);
            cyc();
        end
        sample_valid = 1'b0;
        cyc(); cyc();
        check("b2b_pulses", amp_log.size(), 1000);

        for (int i = 0; i < 600; i++) begin
            if (i % 60 == 0) begin
                a = 4'($urandom_range(0, 6));
                r = 4'($urandom_range(0, 6));
                threshold = 4'($urandom_range(0, 8));
                hold = 4'($urandom_range(0, 1));
            end
            sample_valid = 1'($urandom_range(0, 1));
            din = 12'($urandom);
            cyc();
        end
        sample_valid = 1'b0;
        repeat (3) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
